// File: rtl/trigger_capture.sv
// trigger_capture: hysteresis level trigger that captures a DEPTH-sample window around the trigger and streams it out
module trigger_capture #(
  parameter int DEPTH = 256,
  parameter int PRE = 64,
  parameter int HYST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] data_in,
  input  logic        sample_en,
  input  logic [11:0] level,
  input  logic        slope,
  input  logic        arm,
  input  logic        force_trig,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        armed,
  output logic        triggered,
  output logic        done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READOUT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, start_q, start_d;
  logic [AW:0] cnt_q, cnt_d, beat_q, beat_d;
  logic flag_q, flag_d, trig_q, trig_d, prime_q, prime_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, done_q, done_d;
  logic [11:0] rd_data_q, rd_data_d;
  logic [11:0] mem_q [DEPTH];
  logic [12:0] lo, hi;
  logic wr, rearm, fire, hit, load, last_xfer;
  always_comb begin
    lo = {1'b0, level} >= 13'(HYST) ? {1'b0, level} - 13'(HYST) : 13'd0;
    hi = {1'b0, level} + 13'(HYST) > 13'd4095 ? 13'd4095 : {1'b0, level} + 13'(HYST);
    rearm = slope ? {1'b0, data_in} >= hi : {1'b0, data_in} <= lo;
    fire = slope ? data_in <= level : data_in >= level;
    wr = sample_en && state_q inside {PREFILL, WAIT_TRIG, POST};
    hit = wr && state_q == WAIT_TRIG && (force_trig || (flag_q && fire));
    // prime_q inserts the extra cycle so the first beat appears two cycles into READOUT
    load = state_q == READOUT && prime_q && beat_q < (AW+1)'(DEPTH) && (!rd_valid_q || rd_ready);
    last_xfer = rd_valid_q && rd_ready && rd_last_q;
    state_d = state_q;
    wp_d = wr ? wp_q + 1'b1 : wp_q;
    cnt_d = wr ? cnt_q + 1'b1 : cnt_q;
    flag_d = wr && state_q != POST && rearm ? 1'b1 : flag_q;
    start_d = start_q;
    trig_d = trig_q;
    prime_d = state_q == READOUT;
    rp_d = load ? rp_q + 1'b1 : rp_q;
    beat_d = load ? beat_q + 1'b1 : beat_q;
    rd_data_d = load ? mem_q[rp_q] : rd_data_q;
    rd_last_d = load ? beat_q == (AW+1)'(DEPTH - 1) : rd_last_q;
    rd_valid_d = load || (rd_valid_q && !rd_ready);
    done_d = last_xfer;
    case (state_q)
      IDLE: if (arm) begin
        state_d = PREFILL;
        wp_d = '0;
        cnt_d = '0;
        flag_d = 1'b0;
        trig_d = 1'b0;
      end
      PREFILL: if (wr && cnt_q + 1'b1 == (AW+1)'(PRE)) state_d = WAIT_TRIG;
      WAIT_TRIG: if (hit) begin
        state_d = POST;
        start_d = wp_q - AW'(PRE);
        flag_d = 1'b0;
        trig_d = 1'b1;
        cnt_d = '0;
      end
      POST: if (wr && cnt_q + 1'b1 == (AW+1)'(DEPTH - PRE - 1)) begin
        state_d = READOUT;
        rp_d = start_q;
        beat_d = '0;
      end
      READOUT: if (last_xfer) begin
        state_d = IDLE;
        trig_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      start_q <= '0;
      cnt_q <= '0;
      beat_q <= '0;
      flag_q <= 1'b0;
      trig_q <= 1'b0;
      prime_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
      done_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      start_q <= start_d;
      cnt_q <= cnt_d;
      beat_q <= beat_d;
      flag_q <= flag_d;
      trig_q <= trig_d;
      prime_q <= prime_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
      done_q <= done_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wp_q] <= data_in;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;
  assign armed = state_q inside {PREFILL, WAIT_TRIG, POST};
  assign triggered = trig_q;
  assign done = done_q;
endmodule
